cve2_mem_arbiter: RTL
=====================

CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter
Shares one memory port between the CVE2 instruction and data ports (req/gnt/rvalid protocol); tracks response ownership.

Interface
REQ-001 Parameter MaxOutstanding, default 2, meaning depth of the ownership FIFO (granted, not-yet-responded transactions); legal range 1..4.
REQ-002 clk_i  input  1  sole clock, all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1 each  instruction port handshake.
REQ-005 instr_addr_i  input  32  instruction fetch address.
REQ-006 instr_rdata_o / instr_err_o  output  32/1  fetch response data and error.
REQ-007 data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1 each  data port handshake.
REQ-008 data_we_i / data_be_i / data_addr_i / data_wdata_i  input  1/4/32/32  data request attributes.
REQ-009 data_rdata_o / data_err_o  output  32/1  data response data and error.
REQ-010 mem_req_o / mem_gnt_i / mem_rvalid_i  out/in/in  1 each  shared memory handshake.
REQ-011 mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  output  1/4/32/32  forwarded request attributes.
REQ-012 mem_rdata_i / mem_err_i  input  32/1  memory response.
REQ-013 resp_unexp_o  output  1  one-cycle pulse: mem_rvalid_i arrived with ownership FIFO empty.

Function
REQ-014 Arbiter state: IDLE (no selection held) and HOLD (mem_req_o asserted, gnt not yet received, owner locked).
REQ-015 In IDLE, owner chosen combinationally among active requesters per REQ-027; mem_req_o = 1 when any requester active and FIFO not full.
REQ-016 IDLE->HOLD when mem_req_o=1 and mem_gnt_i=0; HOLD->IDLE on mem_gnt_i=1; in HOLD owner and all mem_* attributes stay stable.
REQ-017 Requester gnt output = mem_gnt_i AND mem_req_o AND (requester is owner); never more than one gnt per cycle.
REQ-018 Instruction requests drive mem_we_o=0, mem_be_o=4'b1111, mem_wdata_o=0.
REQ-019 On mem_req_o AND mem_gnt_i, push owner bit (0=instr,1=data) into ownership FIFO.
REQ-020 On mem_rvalid_i with FIFO non-empty: pop head; assert rvalid only on head owner's port, same cycle (zero latency); rdata/err of both ports mirror mem_rdata_i/mem_err_i.
REQ-021 FIFO full blocks new mem_req_o even if a pop occurs same cycle; HOLD is never entered while full.
REQ-022 Simultaneous push and pop in same cycle (non-full): count unchanged, order preserved.
REQ-023 mem_rvalid_i with FIFO empty: no port rvalid, resp_unexp_o=1 for that cycle, state unchanged.
REQ-024 Requester dropping req in HOLD is a protocol violation; arbiter still holds mem_req_o until gnt (no abort).

Reset
REQ-025 While rst_i=1 at a clock edge: state=IDLE, FIFO empty (pointers and count 0), round-robin pointer favours data, resp_unexp_o=0.
REQ-026 Reset mid-operation discards all outstanding ownership; responses arriving after reset release raise resp_unexp_o, never port rvalid.

Configuration
REQ-027 Macro CVE2_ARB_ROUND_ROBIN_EN defined: on each grant, priority toggles to the other requester; contending requests alternate. Undefined: fixed priority, data over instruction, no priority register.

Verification
REQ-028 Data and instr req together, mem_gnt_i=1, macro undefined -> data_gnt_o=1 every cycle, instr_gnt_o=0 until data_req_i drops.
REQ-029 Same stimulus, CVE2_ARB_ROUND_ROBIN_EN defined -> grants alternate data,instr,data,instr over 4 cycles.
REQ-030 Instr req, mem_gnt_i=0 for 3 cycles then data req arrives -> mem_addr_o stays instr address, instr_gnt_o on 4th cycle when gnt=1.
REQ-031 MaxOutstanding=2, two grants (instr then data), no rvalid -> mem_req_o=0 on third request; rvalid x2 -> instr_rvalid_o then data_rvalid_o, rdata 0xDEADBEEF passed through.
REQ-032 mem_rvalid_i=1 after reset with FIFO empty -> resp_unexp_o=1 one cycle, instr_rvalid_o=data_rvalid_o=0.
REQ-033 rst_i=1 with one transaction outstanding and HOLD active -> next cycle mem_req_o follows IDLE rules, FIFO empty.

Source files
------------

// File: rtl/cve2_mem_arbiter.sv
// Shares one memory port between the CVE2 instruction and data ports and routes
// each response back to its owner. Define CVE2_ARB_ROUND_ROBIN_EN for alternating priority.
module cve2_mem_arbiter #(
    parameter int MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        instr_req_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic [31:0] instr_addr_i,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,

    output logic        resp_unexp_o
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Request attributes captured when a request stalls, so HOLD is immune to requester changes.
    logic        owner_q;
    logic        we_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    // Ownership FIFO: 0 = instruction, 1 = data.
    logic [MaxOutstanding-1:0] fifo_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [CntW-1:0]           count_q;

    logic full;
    logic empty;
    logic any_req;
    logic sel;
    logic owner;
    logic push;
    logic pop;
    logic head;
    logic resp_live;
    logic capture;

    assign full    = (count_q == CntFull);
    assign empty   = (count_q == '0);
    assign any_req = instr_req_i | data_req_i;
    assign head    = fifo_q[rd_ptr_q];

`ifdef CVE2_ARB_ROUND_ROBIN_EN
    logic prio_q;  // 1 favours data, 0 favours instruction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= 1'b1;
        end else if (push) begin
            prio_q <= ~owner;
        end
    end

    always_comb begin
        sel = data_req_i;
        if (instr_req_i && data_req_i) begin
            sel = prio_q;
        end
    end
`else
    always_comb begin
        sel = data_req_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        owner       = sel;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'b1111;
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req_o = any_req & ~full;
                if (sel) begin
                    mem_we_o    = data_we_i;
                    mem_be_o    = data_be_i;
                    mem_addr_o  = data_addr_i;
                    mem_wdata_o = data_wdata_i;
                end
                if (mem_req_o && !mem_gnt_i) begin
                    state_d = HOLD;
                    capture = 1'b1;
                end
            end
            HOLD: begin
                // Stays asserted even if the requester withdraws; no abort path.
                mem_req_o   = 1'b1;
                owner       = owner_q;
                mem_we_o    = we_q;
                mem_be_o    = be_q;
                mem_addr_o  = addr_q;
                mem_wdata_o = wdata_q;
                if (mem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (capture) begin
            owner_q <= owner;
            we_q    <= mem_we_o;
            be_q    <= mem_be_o;
            addr_q  <= mem_addr_o;
            wdata_q <= mem_wdata_o;
        end
    end

    assign push = mem_req_o & mem_gnt_i;

    assign instr_gnt_o = push & ~owner;
    assign data_gnt_o  = push & owner;

    assign resp_live = mem_rvalid_i & ~rst_i;
    assign pop       = resp_live & ~empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= owner;
                wr_ptr_q         <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop & head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;
    assign resp_unexp_o   = resp_live & empty;

endmodule
